// File: rtl/rat_reduce.sv
// Rational normaliser: reduces (num, den) to lowest terms via binary GCD and two restoring divisions.
// Optional cycle counter output enabled by defining RAT_REDUCE_CYCLES_EN.
module rat_reduce #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic             out_err
`ifdef RAT_REDUCE_CYCLES_EN
  ,
  output logic [15:0]      out_cycles
`endif
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GCD,
    S_DIVN,
    S_DIVD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_den;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_bit;
  logic [WIDTH-1:0] r_out_num;
  logic [WIDTH-1:0] r_out_den;
  logic             r_out_err;

  logic             w_capture;
  logic             w_last_bit;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dvd_next;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign w_capture  = in_valid && in_ready;
  assign w_last_bit = (r_bit == CW'(WIDTH - 1));
  assign out_valid  = (r_state == S_DONE);
  assign out_num    = r_out_num;
  assign out_den    = r_out_den;
  assign out_err    = r_out_err;

  // One restoring-division step: r_dvd shifts its MSB into the remainder and
  // collects quotient bits at the LSB. The remainder is always below g, so
  // modular subtraction on the low WIDTH bits is exact.
  assign w_trial    = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_g});
  assign w_rem_next = w_ge ? (w_trial[WIDTH-1:0] - r_g) : w_trial[WIDTH-1:0];
  assign w_dvd_next = {r_dvd[WIDTH-2:0], w_ge};

  // NOTE: defaults first so every path assigns w_next and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_next = ((in_num == '0) || (in_den == '0)) ? S_DONE : S_GCD;
      S_GCD:   if (r_a == r_b) w_next = S_DIVN;
      S_DIVN:  if (w_last_bit) w_next = S_DIVD;
      S_DIVD:  if (w_last_bit) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef RAT_REDUCE_CYCLES_EN
  logic [15:0] r_elapsed;
  logic [15:0] r_out_cycles;
  assign out_cycles = r_out_cycles;

  // r_elapsed equals the index of the current cycle counted from the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_elapsed    <= '0;
      r_out_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_capture) begin
        r_elapsed <= 16'd1;
        if ((in_num == '0) || (in_den == '0)) r_out_cycles <= 16'd1;
      end
    end else if (r_state != S_DONE) begin
      r_elapsed <= r_elapsed + 16'd1;
      if (w_next == S_DONE) r_out_cycles <= r_elapsed + 16'd1;
    end
  end
`endif

  // NOTE: non-blocking assignments keep every register update in this block
  // based on the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_k       <= '0;
      r_g       <= '0;
      r_den     <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_bit     <= '0;
      r_out_num <= '0;
      r_out_den <= '0;
      r_out_err <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            if (in_den == '0) begin
              r_out_num <= (in_num != '0) ? WIDTH'(1) : '0;
              r_out_den <= '0;
              r_out_err <= 1'b1;
            end else if (in_num == '0) begin
              r_out_num <= '0;
              r_out_den <= WIDTH'(1);
              r_out_err <= 1'b0;
            end else begin
              r_a   <= in_num;
              r_b   <= in_den;
              r_k   <= '0;
              r_den <= in_den;
              r_dvd <= in_num;
              r_rem <= '0;
              r_bit <= '0;
            end
          end
        end
        S_GCD: begin
          if (r_a == r_b) begin
            r_g <= r_a << r_k;
          end else if (!r_a[0] && !r_b[0]) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + 1'b1;
          end else if (!r_a[0]) begin
            r_a <= r_a >> 1;
          end else if (!r_b[0]) begin
            r_b <= r_b >> 1;
          end else if (r_a > r_b) begin
            r_a <= (r_a - r_b) >> 1;
          end else begin
            r_b <= (r_b - r_a) >> 1;
          end
        end
        S_DIVN: begin
          r_bit <= r_bit + 1'b1;
          if (w_last_bit) begin
            r_out_num <= w_dvd_next;
            r_dvd     <= r_den;
            r_rem     <= '0;
            r_bit     <= '0;
          end else begin
            r_dvd <= w_dvd_next;
            r_rem <= w_rem_next;
          end
        end
        S_DIVD: begin
          r_bit <= r_bit + 1'b1;
          r_dvd <= w_dvd_next;
          r_rem <= w_rem_next;
          if (w_last_bit) begin
            r_out_den <= w_dvd_next;
            r_out_err <= 1'b0;
            r_bit     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_reduce.sv
// Self-checking bench for rat_reduce: directed corner cases plus randomized fractions
// compared against a Euclid-based reference model.
module tb_rat_reduce;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_num;
  logic [W-1:0] in_den;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_num;
  logic [W-1:0] out_den;
  logic         out_err;
`ifdef RAT_REDUCE_CYCLES_EN
  logic [15:0]  out_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rat_reduce #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_den   (out_den),
    .out_err   (out_err)
`ifdef RAT_REDUCE_CYCLES_EN
    ,
    .out_cycles(out_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference GCD by Euclid's remainder algorithm.
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of Stein iterations before a==b; this sets the documented latency.
  function automatic int stein_steps(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (a != b) begin
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0)          a = a / 2;
      else if (b % 2 == 0)          b = b / 2;
      else if (a > b)               a = (a - b) / 2;
      else                          b = (b - a) / 2;
      n++;
    end
    return n;
  endfunction

  // Submit one fraction, wait for the result, optionally stall the output for
  // 'stall' cycles (keeping 8/12 pending at the input), then complete the handshake.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input int stall);
    logic [W-1:0] en, ed, g;
    logic         ee;
    int           exp_lat, lat, waited;
    if (d == 0) begin
      en = (n != 0) ? 1 : 0; ed = 0; ee = 1'b1; exp_lat = 1;
    end else if (n == 0) begin
      en = 0; ed = 1; ee = 1'b0; exp_lat = 1;
    end else begin
      g = gcd_ref(n, d);
      en = n / g; ed = d / g; ee = 1'b0;
      exp_lat = 2 + stein_steps(n, d) + 2 * W;
    end

    in_num = n; in_den = d; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("capture_timeout", 64'(waited), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", 64'(in_ready), 64'(0));

    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid", 64'(out_valid), 64'(1));
    check("latency", 64'(lat), 64'(exp_lat));
    check("out_num", 64'(out_num), 64'(en));
    check("out_den", 64'(out_den), 64'(ed));
    check("out_err", 64'(out_err), 64'(ee));
`ifdef RAT_REDUCE_CYCLES_EN
    check("out_cycles", 64'(out_cycles), 64'(exp_lat));
`endif

    if (stall > 0) begin
      out_ready = 1'b0;
      in_num = 8; in_den = 12; in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_num", 64'(out_num), 64'(en));
        check("stall_den", 64'(out_den), 64'(ed));
        check("stall_err", 64'(out_err), 64'(ee));
        check("stall_in_ready", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("post_hs_valid", 64'(out_valid), 64'(0));
    check("post_hs_in_ready", 64'(in_ready), 64'(1));
    check("post_hs_num_kept", 64'(out_num), 64'(en));
    check("post_hs_den_kept", 64'(out_den), 64'(ed));
  endtask

  initial begin
    logic [W-1:0] rn, rd, c;
    rst = 1'b1; in_valid = 1'b0; in_num = '0; in_den = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_num", 64'(out_num), 64'(0));
    check("rst_out_den", 64'(out_den), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
`ifdef RAT_REDUCE_CYCLES_EN
    check("rst_out_cycles", 64'(out_cycles), 64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(1));

    do_op(6, 4, 0);
    do_op(420, 420, 0);
    do_op(0, 7, 0);
    do_op(5, 0, 0);
    do_op(0, 0, 0);
    do_op(32'h8000_0000, 32'h4000_0000, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    do_op(9, 12, 10);
    do_op(8, 12, 0);

    // Abort a computation in GCD with a one-cycle reset.
    in_num = 100; in_den = 75; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_out_num", 64'(out_num), 64'(0));
    check("abort_out_den", 64'(out_den), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("abort_rel_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 64'(out_valid), 64'(0));
    end
    do_op(100, 75, 0);

    for (int i = 0; i < 25; i++) begin
      if (i % 5 == 4) begin
        rn = $urandom;
        rd = $urandom;
      end else begin
        c  = $urandom_range(1, 1000);
        rn = $urandom_range(0, 4000) * c;
        rd = $urandom_range(1, 4000) * c;
        if (i % 7 == 3) rd = 0;
      end
      do_op(rn, rd, (i % 6 == 2) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
